multi_mode_counter_p: RTL

Parametrised next-generation multi-mode game counter. A WIDTH-bit counter steps up or down by one of two programmable step sizes, and can be parallel-loaded. It flags each arrival at all-ones (win) or zero (lose) and tallies both events. It ends the game when either tally reaches LIMIT. It is the core of the counter-game datapath; a hold/enable input and run-time score outputs are new.

---
 rtl/mmc_pkg.sv | 23 ++
 rtl/mmc_score.sv | 61 ++++++
 rtl/multi_mode_counter_p.sv | 94 +++++++++
 3 files changed

// File: rtl/mmc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmc_pkg                                                              |
// | Shared encodings for the multi-mode game counter.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mmc_pkg;

    typedef enum logic [1:0] {
        UP_S = 2'b00,
        UP_L = 2'b01,
        DN_S = 2'b10,
        DN_L = 2'b11
    } ctrl_e;

    typedef enum logic [1:0] {
        WHO_NONE = 2'b00,
        WHO_LOSE = 2'b01,
        WHO_WIN  = 2'b10
    } who_e;

endpackage
`default_nettype wire

// File: rtl/mmc_score.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmc_score                                                            |
// | Win/lose tallies and sticky end-of-game flag for the game counter.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mmc_score
    import mmc_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         win_evt,
    input  logic                         lose_evt,
    output logic [$clog2(LIMIT+1)-1:0]   win_cnt,
    output logic [$clog2(LIMIT+1)-1:0]   lose_cnt,
    output logic                         gameover,
    output logic [1:0]                   who
);

    localparam int CW = $clog2(LIMIT+1);
    localparam logic [CW-1:0] c_last = CW'(LIMIT - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    logic [CW-1:0] r_win_cnt;
    logic [CW-1:0] r_lose_cnt;
    logic          r_gameover;
    who_e          r_who;

    // The tally that reaches LIMIT ends the game on the same edge it increments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_cnt  <= '0;
            r_lose_cnt <= '0;
            r_gameover <= 1'b0;
            r_who      <= WHO_NONE;
        end else if (!r_gameover) begin
            if (win_evt) begin
                r_win_cnt <= r_win_cnt + c_one;
                if (r_win_cnt == c_last) begin
                    r_gameover <= 1'b1;
                    r_who      <= WHO_WIN;
                end
            end else if (lose_evt) begin
                r_lose_cnt <= r_lose_cnt + c_one;
                if (r_lose_cnt == c_last) begin
                    r_gameover <= 1'b1;
                    r_who      <= WHO_LOSE;
                end
            end
        end
    end

    assign win_cnt  = r_win_cnt;
    assign lose_cnt = r_lose_cnt;
    assign gameover = r_gameover;
    assign who      = r_who;

endmodule
`default_nettype wire

// File: rtl/multi_mode_counter_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_mode_counter_p                                                 |
// | Up/down two-step game counter with load, hold and win/lose scoring.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module multi_mode_counter_p
    import mmc_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int STEP_SMALL = 1,
    parameter int STEP_LARGE = 2,
    parameter int LIMIT      = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   ctrl,
    input  logic                         init,
    input  logic [WIDTH-1:0]             init_value,
    output logic [WIDTH-1:0]             count,
    output logic                         winner,
    output logic                         loser,
    output logic                         gameover,
    output logic [1:0]                   who,
    output logic [$clog2(LIMIT+1)-1:0]   win_cnt,
    output logic [$clog2(LIMIT+1)-1:0]   lose_cnt
);

    localparam logic [WIDTH-1:0] c_max        = '1;
    localparam logic [WIDTH-1:0] c_step_small = WIDTH'(STEP_SMALL);
    localparam logic [WIDTH-1:0] c_step_large = WIDTH'(STEP_LARGE);

    logic [WIDTH-1:0] r_count;
    logic             r_winner;
    logic             r_loser;
    logic [WIDTH-1:0] w_next;
    logic             w_step_en;
    logic             w_win_evt;
    logic             w_lose_evt;
    logic             w_gameover;

    // Modular add/subtract: large steps are allowed to jump over 0 or MAX.
    always_comb begin
        w_next = r_count + c_step_small;
        case (ctrl_e'(ctrl))
            UP_S:    w_next = r_count + c_step_small;
            UP_L:    w_next = r_count + c_step_large;
            DN_S:    w_next = r_count - c_step_small;
            DN_L:    w_next = r_count - c_step_large;
            default: w_next = r_count + c_step_small;
        endcase
    end

    assign w_step_en  = ~w_gameover & ~init & en;
    assign w_win_evt  = w_step_en & (w_next == c_max);
    assign w_lose_evt = w_step_en & (w_next == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_winner <= 1'b0;
            r_loser  <= 1'b0;
        end else begin
            r_winner <= w_win_evt;
            r_loser  <= w_lose_evt;
            if (!w_gameover && init) begin
                r_count <= init_value;
            end else if (w_step_en) begin
                r_count <= w_next;
            end
        end
    end

    mmc_score #(
        .LIMIT    (LIMIT)
    ) u_score (
        .clk      (clk),
        .rst      (rst),
        .win_evt  (w_win_evt),
        .lose_evt (w_lose_evt),
        .win_cnt  (win_cnt),
        .lose_cnt (lose_cnt),
        .gameover (w_gameover),
        .who      (who)
    );

    assign count    = r_count;
    assign winner   = r_winner;
    assign loser    = r_loser;
    assign gameover = w_gameover;

endmodule
`default_nettype wire
